// File: rtl/compositor_pkg.sv
// Shared types and op-field layout helpers for the frame compositor.
// Field positions are derived from the framebuffer geometry.
package compositor_pkg;

    typedef enum logic [1:0] {
        OP_NOP  = 2'd0,
        OP_RECT = 2'd1,
        OP_END  = 2'd2,
        OP_RSVD = 2'd3
    } opcode_e;

    typedef enum logic [1:0] {
        ST_ARB,
        ST_LOAD,
        ST_DRAW,
        ST_WAIT_SWAP
    } state_e;

    function automatic int x_w(input int hor);
        return $clog2(hor);
    endfunction

    function automatic int y_w(input int ver);
        return $clog2(ver);
    endfunction

    // Layout MSB..LSB: opcode, x, y, w, h, color
    function automatic int h_lo(input int cw);
        return cw;
    endfunction

    function automatic int w_lo(input int ver, input int cw);
        return h_lo(cw) + y_w(ver) + 1;
    endfunction

    function automatic int y_lo(input int hor, input int ver, input int cw);
        return w_lo(ver, cw) + x_w(hor) + 1;
    endfunction

    function automatic int x_lo(input int hor, input int ver, input int cw);
        return y_lo(hor, ver, cw) + y_w(ver);
    endfunction

    function automatic int opc_lo(input int hor, input int ver, input int cw);
        return x_lo(hor, ver, cw) + x_w(hor);
    endfunction

    function automatic int op_w(input int hor, input int ver, input int cw);
        return opc_lo(hor, ver, cw) + 2;
    endfunction

    function automatic int addr_w(input int hor, input int ver, input int db);
        return $clog2((1 + db) * hor * ver);
    endfunction

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/frame_compositor_rr_arbiter.sv
// Round-robin request arbiter; the pointer moves past the winner
// only when the grant is accepted.
module rr_arbiter
    import compositor_pkg::*;
#(
    parameter int N = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ce,
    input  logic                 accept,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         grant,
    output logic [idx_w(N)-1:0]  grant_idx,
    output logic                 valid
);

    localparam int IW = idx_w(N);

    logic [IW-1:0] ptr;
    logic [IW-1:0] cand [N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            cand[i] = IW'((int'(ptr) + i) % N);
        end
    end

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        valid     = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!valid && req[cand[i]]) begin
                valid           = 1'b1;
                grant_idx       = cand[i];
                grant[cand[i]]  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (ce && accept) begin
            ptr <= (int'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/frame_compositor.sv
// Multi-source rectangle rasteriser with frame-level double buffering.
// Ops are arbitrated round-robin, clipped once, then drawn one pixel per cycle.
module frame_compositor
    import compositor_pkg::*;
#(
    parameter int HOR_ACTIVE_PIXELS = 640,
    parameter int VER_ACTIVE_PIXELS = 480,
    parameter int NUM_SOURCES       = 2,
    parameter int COLOR_WIDTH       = 1,
    parameter int DOUBLE_BUFFER     = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic ce,
    input  logic swap,
    input  logic [NUM_SOURCES*op_w(HOR_ACTIVE_PIXELS, VER_ACTIVE_PIXELS, COLOR_WIDTH)-1:0] src_op,
    input  logic [NUM_SOURCES-1:0] src_empty,
    output logic [NUM_SOURCES-1:0] src_rd_en,
    output logic wr_en,
    output logic [addr_w(HOR_ACTIVE_PIXELS, VER_ACTIVE_PIXELS, DOUBLE_BUFFER)-1:0] wr_addr,
    output logic [COLOR_WIDTH-1:0] wr_data,
    output logic buf_sel,
    output logic frame_done,
    output logic busy
);

    localparam int HOR    = HOR_ACTIVE_PIXELS;
    localparam int VER    = VER_ACTIVE_PIXELS;
    localparam int NS     = NUM_SOURCES;
    localparam int X_W    = x_w(HOR);
    localparam int Y_W    = y_w(VER);
    localparam int XC     = X_W + 1;
    localparam int YC     = Y_W + 1;
    localparam int XS     = X_W + 2;
    localparam int YS     = Y_W + 2;
    localparam int OP_W   = op_w(HOR, VER, COLOR_WIDTH);
    localparam int AW     = addr_w(HOR, VER, DOUBLE_BUFFER);
    localparam int IW     = idx_w(NS);
    localparam int H_LO   = h_lo(COLOR_WIDTH);
    localparam int W_LO   = w_lo(VER, COLOR_WIDTH);
    localparam int Y_LO   = y_lo(HOR, VER, COLOR_WIDTH);
    localparam int X_LO   = x_lo(HOR, VER, COLOR_WIDTH);
    localparam int OPC_LO = opc_lo(HOR, VER, COLOR_WIDTH);

    state_e          state, state_d;
    logic [OP_W-1:0] op_q, pick_op;
    logic [IW-1:0]   src_q;
    logic [NS-1:0]   done_mask, mask_set;
    logic            buf_q;
    logic [XC-1:0]   x0, xe, x_cur;
    logic [YC-1:0]   ye, y_cur;
    logic [AW-1:0]   row_base, buf_offset;

    logic [NS-1:0]   grant;
    logic [IW-1:0]   grant_idx;
    logic            grant_valid;
    logic            accept;

    opcode_e         opc;
    logic [X_W-1:0]  op_x;
    logic [Y_W-1:0]  op_y;
    logic [XC-1:0]   op_wd;
    logic [YC-1:0]   op_ht;
    logic [XS-1:0]   x_sum;
    logic [YS-1:0]   y_sum;
    logic [XC-1:0]   xe_n;
    logic [YC-1:0]   ye_n;
    logic            clip_empty;
    logic            last_px;

    assign accept = ce && !rst && (state == ST_ARB) && grant_valid;

    rr_arbiter #(.N(NS)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .accept    (accept),
        .req       (~src_empty & ~done_mask),
        .grant     (grant),
        .grant_idx (grant_idx),
        .valid     (grant_valid)
    );

    always_comb begin
        pick_op = '0;
        for (int i = 0; i < NS; i++) begin
            if (grant[i]) pick_op = src_op[i*OP_W +: OP_W];
        end
    end

    assign opc   = opcode_e'(op_q[OPC_LO +: 2]);
    assign op_x  = op_q[X_LO +: X_W];
    assign op_y  = op_q[Y_LO +: Y_W];
    assign op_wd = op_q[W_LO +: XC];
    assign op_ht = op_q[H_LO +: YC];

    // Clip once on load so the draw loop only compares against bounds
    assign x_sum = {2'b00, op_x} + {1'b0, op_wd};
    assign y_sum = {2'b00, op_y} + {1'b0, op_ht};
    assign xe_n  = (x_sum > XS'(HOR)) ? XC'(HOR) : x_sum[XC-1:0];
    assign ye_n  = (y_sum > YS'(VER)) ? YC'(VER) : y_sum[YC-1:0];

    assign clip_empty = (op_wd == '0) || (op_ht == '0) ||
                        ({1'b0, op_x} >= XC'(HOR)) ||
                        ({1'b0, op_y} >= YC'(VER));

    assign buf_offset = buf_q ? AW'(HOR * VER) : '0;
    assign mask_set   = done_mask | (NS'(1) << src_q);
    assign last_px    = (x_cur + 1'b1 == xe) && (y_cur + 1'b1 == ye);

    always_comb begin
        state_d    = state;
        src_rd_en  = '0;
        frame_done = 1'b0;
        unique case (state)
            ST_ARB: begin
                if (grant_valid) begin
                    state_d   = ST_LOAD;
                    src_rd_en = grant & {NS{ce & ~rst}};
                end
            end
            ST_LOAD: begin
                unique case (opc)
                    OP_RECT: state_d = clip_empty ? ST_ARB : ST_DRAW;
                    OP_END: begin
                        if (&mask_set) begin
                            state_d    = ST_WAIT_SWAP;
                            frame_done = ce & ~rst;
                        end else begin
                            state_d = ST_ARB;
                        end
                    end
                    default: state_d = ST_ARB;
                endcase
            end
            ST_DRAW: begin
                if (last_px) state_d = ST_ARB;
            end
            ST_WAIT_SWAP: begin
                if (swap) state_d = ST_ARB;
            end
            default: state_d = ST_ARB;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_ARB;
            op_q      <= '0;
            src_q     <= '0;
            done_mask <= '0;
            buf_q     <= 1'b0;
            x0        <= '0;
            xe        <= '0;
            ye        <= '0;
            x_cur     <= '0;
            y_cur     <= '0;
            row_base  <= '0;
        end else if (ce) begin
            state <= state_d;
            unique case (state)
                ST_ARB: begin
                    if (grant_valid) begin
                        op_q  <= pick_op;
                        src_q <= grant_idx;
                    end
                end
                ST_LOAD: begin
                    x0       <= {1'b0, op_x};
                    x_cur    <= {1'b0, op_x};
                    y_cur    <= {1'b0, op_y};
                    xe       <= xe_n;
                    ye       <= ye_n;
                    row_base <= buf_offset + AW'(op_y) * AW'(HOR);
                    if (opc == OP_END) done_mask <= mask_set;
                end
                ST_DRAW: begin
                    if (x_cur + 1'b1 == xe) begin
                        x_cur    <= x0;
                        y_cur    <= y_cur + 1'b1;
                        row_base <= row_base + AW'(HOR);
                    end else begin
                        x_cur <= x_cur + 1'b1;
                    end
                end
                ST_WAIT_SWAP: begin
                    if (swap) begin
                        done_mask <= '0;
                        if (DOUBLE_BUFFER != 0) buf_q <= ~buf_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign wr_en   = (state == ST_DRAW);
    assign wr_addr = row_base + AW'(x_cur);
    assign wr_data = op_q[COLOR_WIDTH-1:0];
    assign buf_sel = buf_q;
    assign busy    = (state == ST_LOAD) || (state == ST_DRAW);

endmodule

// File: tb/tb_frame_compositor.sv
// Directed bench for frame_compositor on an 8x4, 2-bit, 2-source setup.
// FIFOs are modelled as arrays; pops and writes are logged per ce cycle.
module tb_frame_compositor;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic        swap;
    logic [31:0] src_op;
    logic [1:0]  src_empty;
    logic [1:0]  src_rd_en;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [1:0]  wr_data;
    logic        buf_sel;
    logic        frame_done;
    logic        busy;

    frame_compositor #(
        .HOR_ACTIVE_PIXELS (8),
        .VER_ACTIVE_PIXELS (4),
        .NUM_SOURCES       (2),
        .COLOR_WIDTH       (2),
        .DOUBLE_BUFFER     (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ce         (ce),
        .swap       (swap),
        .src_op     (src_op),
        .src_empty  (src_empty),
        .src_rd_en  (src_rd_en),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .buf_sel    (buf_sel),
        .frame_done (frame_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [2][64];
    logic [5:0]  wp [2];
    logic [5:0]  rp [2] = '{6'd0, 6'd0};

    always_comb begin
        src_op    = '0;
        src_empty = '1;
        for (int i = 0; i < 2; i++) begin
            src_empty[i]       = (rp[i] == wp[i]);
            src_op[i*16 +: 16] = mem[i][rp[i]];
        end
    end

    int pop_src [64];
    int pop_t   [64];
    int w_addr  [64];
    int w_data  [64];
    int w_t     [64];
    int npop = 0;
    int nw   = 0;
    int nfd  = 0;
    int cec  = 0;

    always @(posedge clk) begin
        if (ce) begin
            for (int i = 0; i < 2; i++) begin
                if (src_rd_en[i]) begin
                    pop_src[npop] = i;
                    pop_t[npop]   = cec;
                    npop          = npop + 1;
                    rp[i] <= rp[i] + 6'd1;
                end
            end
            if (wr_en) begin
                w_addr[nw] = int'(wr_addr);
                w_data[nw] = int'(wr_data);
                w_t[nw]    = cec;
                nw         = nw + 1;
            end
            if (frame_done) nfd = nfd + 1;
            cec = cec + 1;
        end
    end

    int npass  = 0;
    int nfail  = 0;
    int ntotal = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] mk(input logic [1:0] o, input int x,
                                       input int y, input int w,
                                       input int h, input int c);
        return {o, 3'(x), 2'(y), 4'(w), 3'(h), 2'(c)};
    endfunction

    task automatic push(input int s, input logic [15:0] op);
        mem[s][wp[s]] = op;
        wp[s] = wp[s] + 6'd1;
    endtask

    task automatic cyc_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    int bw, bp, bfd;
    bit found;
    int e1 [4] = '{9, 10, 17, 18};
    int e3a [4] = '{0, 2, 1, 3};
    int e3s [4] = '{0, 1, 0, 1};

    initial begin
        wp[0] = 6'd0;
        wp[1] = 6'd0;
        rst   = 1'b1;
        ce    = 1'b1;
        swap  = 1'b0;
        cyc_n(3);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_buf_sel", buf_sel, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_rd_en", src_rd_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        rst = 1'b0;
        cyc_n(1);

        // 2x2 rect, latency and raster order
        bw = nw; bp = npop;
        push(0, mk(2'd1, 1, 1, 2, 2, 3));
        cyc_n(10);
        chk("t1_pops", npop - bp, 1);
        chk("t1_writes", nw - bw, 4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t1_addr%0d", k), w_addr[bw+k], e1[k]);
            chk($sformatf("t1_data%0d", k), w_data[bw+k], 3);
            chk($sformatf("t1_time%0d", k), w_t[bw+k], pop_t[bp] + 2 + k);
        end

        // clipped rect at bottom-right corner
        bw = nw;
        push(0, mk(2'd1, 6, 3, 4, 3, 1));
        cyc_n(10);
        chk("t2_writes", nw - bw, 2);
        chk("t2_addr0", w_addr[bw], 30);
        chk("t2_addr1", w_addr[bw+1], 31);
        chk("t2_data", w_data[bw], 1);

        // zero-width rect
        bw = nw; bp = npop;
        push(0, mk(2'd1, 0, 0, 0, 2, 1));
        cyc_n(6);
        chk("t2z_writes", nw - bw, 0);
        chk("t2z_pops", npop - bp, 1);
        chk("t2z_busy", busy, 0);

        // swap outside WAIT_SWAP is ignored
        swap = 1'b1;
        cyc_n(1);
        swap = 1'b0;
        cyc_n(1);
        chk("swap_ignored", buf_sel, 0);

        rst = 1'b1;
        cyc_n(2);
        rst = 1'b0;

        // round-robin alternation
        bw = nw; bp = npop;
        push(0, mk(2'd1, 0, 0, 1, 1, 1));
        push(0, mk(2'd1, 1, 0, 1, 1, 1));
        push(1, mk(2'd1, 2, 0, 1, 1, 2));
        push(1, mk(2'd1, 3, 0, 1, 1, 2));
        cyc_n(20);
        chk("t3_pops", npop - bp, 4);
        chk("t3_writes", nw - bw, 4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t3_src%0d", k), pop_src[bp+k], e3s[k]);
            chk($sformatf("t3_addr%0d", k), w_addr[bw+k], e3a[k]);
        end

        // frame completion and swap
        bw = nw; bp = npop; bfd = nfd;
        push(0, mk(2'd2, 0, 0, 0, 0, 0));
        push(0, mk(2'd1, 0, 0, 1, 1, 1));
        push(1, mk(2'd1, 4, 1, 1, 1, 2));
        push(1, mk(2'd2, 0, 0, 0, 0, 0));
        cyc_n(25);
        chk("t4_pops", npop - bp, 3);
        chk("t4_src0", pop_src[bp], 0);
        chk("t4_src1", pop_src[bp+1], 1);
        chk("t4_src2", pop_src[bp+2], 1);
        chk("t4_writes", nw - bw, 1);
        chk("t4_addr", w_addr[bw], 12);
        chk("t4_frame_done", nfd - bfd, 1);
        chk("t4_hold_rd_en", src_rd_en, 0);
        chk("t4_hold_buf", buf_sel, 0);
        swap = 1'b1;
        cyc_n(1);
        swap = 1'b0;
        chk("t4_buf_sel", buf_sel, 1);
        cyc_n(10);
        chk("t4_pops_after", npop - bp, 4);
        chk("t4_writes_after", nw - bw, 2);
        chk("t4_addr_buf1", w_addr[bw+1], 32);
        chk("t4_frame_done_once", nfd - bfd, 1);

        // reset during the second pixel
        bw = nw; bp = npop;
        push(0, mk(2'd1, 1, 1, 2, 2, 3));
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (wr_en === 1'b1 && wr_addr === 6'd42) found = 1'b1;
        end
        chk("t6_second_px", found, 1);
        rst = 1'b1;
        cyc_n(1);
        rst = 1'b0;
        chk("t6_wr_en", wr_en, 0);
        chk("t6_buf_sel", buf_sel, 0);
        cyc_n(10);
        chk("t6_writes", nw - bw, 2);
        chk("t6_pops", npop - bp, 1);

        // clock-enable toggling
        bw = nw; bp = npop;
        ce = 1'b0;
        push(0, mk(2'd1, 1, 1, 2, 2, 3));
        #1;
        chk("t5_rd_en_ce0", src_rd_en, 0);
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            ce = ~ce;
        end
        ce = 1'b1;
        cyc_n(2);
        chk("t5_pops", npop - bp, 1);
        chk("t5_writes", nw - bw, 4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t5_addr%0d", k), w_addr[bw+k], e1[k]);
            chk($sformatf("t5_time%0d", k), w_t[bw+k], pop_t[bp] + 2 + k);
        end

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule

// File: doc/frame_compositor.md
Name: frame_compositor

Overview:
- Multi-source successor to the single-CPU render path.
- Drains GPU op streams from NUM_SOURCES first-word-fall-through FIFOs using round-robin arbitration.
- Rasterises clipped rectangle fills into a COLOR_WIDTH-bit framebuffer, writing one pixel per enabled cycle.
- Owns double-buffer selection: a frame completes when every source has issued END_FRAME, then the block holds until `swap`.

Parameters:
- HOR_ACTIVE_PIXELS, 640, visible columns.
- VER_ACTIVE_PIXELS, 480, visible rows.
- NUM_SOURCES, 2, number of op producers (1..8).
- COLOR_WIDTH, 1, bits per pixel.
- DOUBLE_BUFFER, 1, 1 = two frame regions in the framebuffer, 0 = single region.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- ce  in  1  clock enable; every register updates only when ce=1.
- swap  in  1  display has latched the finished frame; sampled only in WAIT_SWAP.
- src_op  in  NUM_SOURCES*OP_WIDTH  packed ops; source i occupies slice i; valid while src_empty[i]=0.
- src_empty  in  NUM_SOURCES  FIFO empty flags.
- src_rd_en  out  NUM_SOURCES  pop strobes; combinational, at most one bit high.
- wr_en  out  1  framebuffer write; the sink writes on wr_en & ce.
- wr_addr  out  ADDR_WIDTH  pixel address: buf_offset + y*HOR_ACTIVE_PIXELS + x.
- wr_data  out  COLOR_WIDTH  pixel colour.
- buf_sel  out  1  buffer currently being drawn; tied 0 when DOUBLE_BUFFER=0.
- frame_done  out  1  one-ce-cycle pulse when the last END_FRAME is consumed.
- busy  out  1  high in LOAD and DRAW.

Behaviour:
- Op format, MSB to LSB: opcode[1:0], x[X_W], y[Y_W], w[X_W+1], h[Y_W+1], color[COLOR_WIDTH].
  - X_W = clog2(HOR), Y_W = clog2(VER).
  - ADDR_WIDTH = clog2((1+DOUBLE_BUFFER)*HOR*VER).
- Opcodes: 0 NOP, 1 RECT, 2 END_FRAME, 3 reserved (treated as NOP).
- Reset values: state ARB, all outputs 0, rr pointer 0, done mask 0, buf_sel 0.
- States:
  - ARB: selects the first source at or after the rr pointer with src_empty=0 and done_mask=0.
    - Asserts src_rd_en for that source (gated by ce) and latches its op the same cycle.
    - rr pointer moves to selected+1, wrapping modulo NUM_SOURCES.
    - Next state LOAD, or stays in ARB if no source is eligible.
  - LOAD (1 cycle):
    - RECT: computes xe = min(x+w, HOR) and ye = min(y+h, VER), and sets row_base = buf_offset + y*HOR using a shift/add-free initial multiply. That multiply may be a registered constant multiply.
    - If w=0, h=0, x>=HOR or y>=VER, returns to ARB with no writes. Otherwise goes to DRAW.
    - NOP: back to ARB.
    - END_FRAME: sets done_mask[src]. If the mask becomes all ones, pulses frame_done and enters WAIT_SWAP; otherwise goes to ARB.
  - DRAW:
    - One write per ce cycle, in raster order: x from x0 to xe-1, then y+1, with row_base += HOR (no multiplier in the loop).
    - After the last pixel, wr_en drops and the state returns to ARB.
  - WAIT_SWAP:
    - No pops.
    - On swap=1: toggles buf_sel (if DOUBLE_BUFFER), clears done_mask, returns to ARB.
- Latency: pop in cycle N; first wr_en at ce-cycle N+2; throughput 1 pixel/ce cycle within a rect.
- Per-source op order is preserved. A source that has ended its frame is skipped until swap, and its subsequent ops wait in its FIFO.
- swap outside WAIT_SWAP is ignored.
- ce=0 freezes everything. src_rd_en is forced low while ce=0.
- rst mid-DRAW: the next cycle shows wr_en=0, the in-flight op is dropped, and no source is popped.

Decomposition:
- Package `compositor_pkg`: opcode enum, op field offset/width functions of (HOR, VER, COLOR_WIDTH), state enum.
- Sub-module `rr_arbiter` (NUM_SOURCES request/grant, pointer advance on accept).

Test Plan (HOR=8, VER=4, COLOR_WIDTH=2, NUM_SOURCES=2, ce=1 unless stated):
- Src0 RECT x=1,y=1,w=2,h=2,c=3 -> writes addr 9,10,17,18 on consecutive cycles, data 3, first write 2 cycles after pop.
- RECT x=6,y=3,w=4,h=3 -> only addr 30,31 written. RECT w=0 -> no writes, back to ARB.
- Both sources preloaded with 2 one-pixel RECTs -> pop order src0,src1,src0,src1.
- Src0 END_FRAME then 1 RECT, src1 RECT, src1 END_FRAME:
  - src1 RECT drawn; src0 RECT not popped.
  - frame_done pulses once; no pops until swap.
  - After swap, buf_sel=1 and src0 RECT x=0,y=0,w=1,h=1 writes addr 32.
- Case 1 repeated with ce toggling every cycle -> same 4 writes, each with wr_en&ce high exactly once.
- rst asserted during the 2nd pixel of case 1 -> wr_en=0 next cycle, remaining pixels never written, buf_sel=0.
